// File: rtl/acc_exec_ctrl_pkg.sv
// Shared constants for the accumulator execution controller and its ALU.
package acc_exec_ctrl_pkg;

    // Opcodes accepted on the op_valid/op_ready handshake
    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_ADC = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_AND = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_CLR = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    // ALU control codes
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_NOTA = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2
    } state_t;

endpackage

// File: rtl/acc_flag_reg.sv
// Accumulator plus Z/N/C/V flags; acc/ZN and C/V groups load independently.
module acc_flag_reg #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         acc_ld,
    input  logic [n-1:0] acc_wdata,
    input  logic         cv_ld,
    input  logic         c_wdata,
    input  logic         v_wdata,
    output logic [n-1:0] acc,
    output logic         flag_z,
    output logic         flag_n,
    output logic         flag_c,
    output logic         flag_v
);

    logic [n-1:0] acc_q, acc_d;
    logic         z_q, z_d, neg_q, neg_d, c_q, c_d, v_q, v_d;

    // Next-state: Z/N derive from the value being loaded into acc
    always_comb begin
        acc_d = acc_q;
        z_d   = z_q;
        neg_d = neg_q;
        c_d   = c_q;
        v_d   = v_q;
        if (acc_ld) begin
            acc_d = acc_wdata;
            z_d   = (acc_wdata == '0);
            neg_d = acc_wdata[n-1];
        end
        if (cv_ld) begin
            c_d = c_wdata;
            v_d = v_wdata;
        end
    end

    // Register bank with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            z_q   <= 1'b0;
            neg_q <= 1'b0;
            c_q   <= 1'b0;
            v_q   <= 1'b0;
        end else begin
            acc_q <= acc_d;
            z_q   <= z_d;
            neg_q <= neg_d;
            c_q   <= c_d;
            v_q   <= v_d;
        end
    end

    assign acc    = acc_q;
    assign flag_z = z_q;
    assign flag_n = neg_q;
    assign flag_c = c_q;
    assign flag_v = v_q;

endmodule

// File: rtl/alu_nbit.sv
// Combinational n-bit ALU: add/sub with carry and signed overflow, OR, AND, NOT.
module alu_nbit
    import acc_exec_ctrl_pkg::*;
#(
    parameter int n = 8
) (
    input  logic [n-1:0] in0,
    input  logic [n-1:0] in1,
    input  logic         c_in,
    input  logic [2:0]   ctrl,
    output logic [n-1:0] out,
    output logic         c_out,
    output logic         v
);

    logic [n:0]   sum;
    logic [n-1:0] b;

    // Result select; subtraction is in0 + ~in1 + c_in so c_out is no-borrow
    always_comb begin
        out   = '0;
        c_out = 1'b0;
        v     = 1'b0;
        sum   = '0;
        b     = (ctrl == ALU_SUB) ? ~in1 : in1;
        case (ctrl)
            ALU_ADD, ALU_SUB: begin
                sum   = {1'b0, in0} + {1'b0, b} + {{n{1'b0}}, c_in};
                out   = sum[n-1:0];
                c_out = sum[n];
                v     = (in0[n-1] == b[n-1]) && (sum[n-1] != in0[n-1]);
            end
            ALU_OR:   out = in0 | in1;
            ALU_AND:  out = in0 & in1;
            ALU_NOTA: out = ~in0;
            default:  out = '0;
        endcase
    end

endmodule

// File: rtl/acc_exec_ctrl.sv
// Execution controller: op handshake, ALU drive, writeback and shift-add multiply.
module acc_exec_ctrl
    import acc_exec_ctrl_pkg::*;
#(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [3:0]   opcode,
    input  logic [n-1:0] operand,
    output logic [n-1:0] alu_in0,
    output logic [n-1:0] alu_in1,
    output logic         alu_c_in,
    output logic [2:0]   alu_ctrl,
    input  logic [n-1:0] alu_out,
    input  logic         alu_c_out,
    input  logic         alu_v,
    output logic [n-1:0] acc,
    output logic         flag_z,
    output logic         flag_n,
    output logic         flag_c,
    output logic         flag_v,
    output logic         done,
    output logic         illegal
);

    localparam int CW = (n > 1) ? $clog2(n) : 1;
    localparam logic [CW-1:0] LAST = CW'(n - 1);

    state_t       state_q, state_d;
    logic [3:0]   opcode_q, opcode_d;
    logic [n-1:0] operand_q, operand_d;
    logic [n-1:0] mcand_q, mcand_d, mplier_q, mplier_d, prod_q, prod_d;
    logic         sticky_q, sticky_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic         done_q, done_d, illegal_q, illegal_d;

    logic         acc_ld, cv_ld, c_wdata, v_wdata;
    logic [n-1:0] acc_wdata;

    acc_flag_reg #(.n(n)) u_acc_flag_reg (
        .clk       (clk),
        .rst       (rst),
        .acc_ld    (acc_ld),
        .acc_wdata (acc_wdata),
        .cv_ld     (cv_ld),
        .c_wdata   (c_wdata),
        .v_wdata   (v_wdata),
        .acc       (acc),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .flag_v    (flag_v)
    );

    // Next-state, ALU drive and writeback control
    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prod_d    = prod_q;
        sticky_d  = sticky_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        alu_in0   = '0;
        alu_in1   = '0;
        alu_c_in  = 1'b0;
        alu_ctrl  = ALU_ADD;
        acc_ld    = 1'b0;
        acc_wdata = '0;
        cv_ld     = 1'b0;
        c_wdata   = 1'b0;
        v_wdata   = 1'b0;
        op_ready  = (state_q == ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    opcode_d  = opcode;
                    operand_d = operand;
                    if (opcode == OP_MUL) begin
                        state_d  = ST_MUL;
                        mcand_d  = acc;
                        mplier_d = operand;
                        prod_d   = '0;
                        sticky_d = 1'b0;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                alu_in0 = acc;
                alu_in1 = operand_q;
                case (opcode_q)
                    OP_LDA: begin
                        acc_ld    = 1'b1;
                        acc_wdata = operand_q;
                    end
                    OP_ADD, OP_ADC, OP_SUB: begin
                        alu_ctrl  = (opcode_q == OP_SUB) ? ALU_SUB : ALU_ADD;
                        alu_c_in  = (opcode_q == OP_SUB) ? 1'b1
                                  : (opcode_q == OP_ADC) ? flag_c : 1'b0;
                        acc_ld    = 1'b1;
                        acc_wdata = alu_out;
                        cv_ld     = 1'b1;
                        c_wdata   = alu_c_out;
                        v_wdata   = alu_v;
                    end
                    OP_OR, OP_AND, OP_NOT: begin
                        alu_ctrl  = (opcode_q == OP_OR)  ? ALU_OR
                                  : (opcode_q == OP_AND) ? ALU_AND : ALU_NOTA;
                        acc_ld    = 1'b1;
                        acc_wdata = alu_out;
                        cv_ld     = 1'b1;
                    end
                    OP_CLR: acc_ld = 1'b1;
                    OP_NOP, OP_MUL: ;
                    default: illegal_d = 1'b1;
                endcase
            end
            ST_MUL: begin
                alu_in0  = prod_q;
                alu_in1  = mplier_q[cnt_q] ? (mcand_q << cnt_q) : '0;
                prod_d   = alu_out;
                sticky_d = sticky_q | alu_c_out;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    done_d    = 1'b1;
                    acc_ld    = 1'b1;
                    acc_wdata = alu_out;
                    cv_ld     = 1'b1;
                    c_wdata   = sticky_d;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            opcode_q  <= '0;
            operand_q <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            prod_q    <= '0;
            sticky_q  <= 1'b0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            prod_q    <= prod_d;
            sticky_q  <= sticky_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign done    = done_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_acc_exec_ctrl.sv
// Scoreboard bench for acc_exec_ctrl driving a real alu_nbit.
module tb_acc_exec_ctrl;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         op_valid;
    logic         op_ready;
    logic [3:0]   opcode;
    logic [N-1:0] operand;
    logic [N-1:0] alu_in0, alu_in1, alu_out, acc;
    logic         alu_c_in, alu_c_out, alu_v;
    logic [2:0]   alu_ctrl;
    logic         flag_z, flag_n, flag_c, flag_v, done, illegal;

    acc_exec_ctrl #(.n(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .opcode    (opcode),
        .operand   (operand),
        .alu_in0   (alu_in0),
        .alu_in1   (alu_in1),
        .alu_c_in  (alu_c_in),
        .alu_ctrl  (alu_ctrl),
        .alu_out   (alu_out),
        .alu_c_out (alu_c_out),
        .alu_v     (alu_v),
        .acc       (acc),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .done      (done),
        .illegal   (illegal)
    );

    alu_nbit #(.n(N)) u_alu (
        .in0   (alu_in0),
        .in1   (alu_in1),
        .c_in  (alu_c_in),
        .ctrl  (alu_ctrl),
        .out   (alu_out),
        .c_out (alu_c_out),
        .v     (alu_v)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   acc;
        logic z, n, c, v, ill;
        int   due;
    } exp_t;

    exp_t sbq[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Reference architectural state
    int   m_acc = 0;
    logic m_z = 0, m_n = 0, m_c = 0, m_v = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int to_signed8(input int x);
        return (x > 127) ? x - 256 : x;
    endfunction

    // Architectural effect of one accepted op, pushed with its expected done cycle
    task automatic model_op(input logic [3:0] op, input logic [7:0] b, input int acc_cyc);
        int a, bi, res, s, r, cin, p;
        logic wacc, wcv, nc, nv, ill;
        exp_t e;
        a = m_acc; bi = int'(b);
        res = 0; wacc = 0; wcv = 0; nc = 0; nv = 0; ill = 0;
        case (op)
            4'd0: ;
            4'd1: begin res = bi; wacc = 1; end
            4'd2, 4'd3: begin
                cin = (op == 4'd3) ? int'(m_c) : 0;
                s = a + bi + cin;
                res = s % 256; nc = (s > 255);
                r = to_signed8(a) + to_signed8(bi) + cin;
                nv = (r > 127) || (r < -128);
                wacc = 1; wcv = 1;
            end
            4'd4: begin
                res = (a - bi + 256) % 256; nc = (a >= bi);
                r = to_signed8(a) - to_signed8(bi);
                nv = (r > 127) || (r < -128);
                wacc = 1; wcv = 1;
            end
            4'd5: begin res = a | bi; wacc = 1; wcv = 1; end
            4'd6: begin res = a & bi; wacc = 1; wcv = 1; end
            4'd7: begin res = 255 - a; wacc = 1; wcv = 1; end
            4'd8: begin res = 0; wacc = 1; end
            4'd9: begin
                p = 0;
                for (int i = 0; i < N; i++) begin
                    if ((bi >> i) & 1) begin
                        p = p + ((a << i) & 255);
                        if (p > 255) nc = 1;
                        p = p & 255;
                    end
                end
                res = p; wacc = 1; wcv = 1;
            end
            default: ill = 1;
        endcase
        if (wacc) begin
            m_acc = res; m_z = (res == 0); m_n = ((res >> 7) & 1) != 0;
        end
        if (wcv) begin
            m_c = nc; m_v = nv;
        end
        e.acc = m_acc; e.z = m_z; e.n = m_n; e.c = m_c; e.v = m_v; e.ill = ill;
        e.due = acc_cyc + ((op == 4'd9) ? N : 1);
        sbq.push_back(e);
    endtask

    // Monitor: every done pulse is matched against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst !== 1'b1) begin
            if (done) begin
                if (sbq.size() == 0) begin
                    chk("spurious_done", 32'(done), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("acc", 32'(acc), 32'(e.acc));
                    chk("flags_znvc", {28'd0, flag_z, flag_n, flag_c, flag_v},
                        {28'd0, e.z, e.n, e.c, e.v});
                    chk("illegal", 32'(illegal), 32'(e.ill));
                    chk("done_latency", 32'(cyc), 32'(e.due));
                end
            end else if (illegal) begin
                chk("illegal_without_done", 32'(illegal), 32'd0);
            end
        end
    end

    // Issue one op at a negedge; while busy, drive ignored junk on the inputs
    task automatic issue(input logic [3:0] op, input logic [7:0] b);
        int t;
        t = 0;
        while (!op_ready) begin
            @(negedge clk);
            t++;
            if (t > 50) begin
                chk("ready_timeout", 32'(op_ready), 32'd1);
                return;
            end
        end
        op_valid = 1'b1; opcode = op; operand = b;
        @(posedge clk);
        #1;
        model_op(op, b, cyc);
        op_valid = 1'($urandom_range(0, 1));
        opcode = 4'($urandom); operand = 8'($urandom);
        t = 0;
        forever begin
            @(negedge clk);
            if (op_ready) break;
            t++;
            if (t > 50) begin
                chk("busy_timeout", 32'(op_ready), 32'd1);
                break;
            end
            op_valid = 1'($urandom_range(0, 1));
            opcode = 4'($urandom); operand = 8'($urandom);
        end
        op_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 || !op_ready) begin
            @(negedge clk);
            t++;
            if (t > 100) begin
                chk("drain_timeout", 32'(sbq.size()), 32'd0);
                sbq.delete();
                return;
            end
        end
        @(negedge clk);
    endtask

    task automatic chk_state(input string tag, input int e_acc, input logic [3:0] e_zncv);
        chk({tag, "_acc"}, 32'(acc), 32'(e_acc));
        chk({tag, "_zncv"}, {28'd0, flag_z, flag_n, flag_c, flag_v}, {28'd0, e_zncv});
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b1; opcode = 4'd1; operand = 8'h55;
        repeat (3) @(negedge clk);
        chk_state("reset", 0, 4'b0000);
        chk("reset_ready", 32'(op_ready), 32'd1);
        chk("reset_done", 32'(done), 32'd0);
        rst = 1'b0; op_valid = 1'b0;
        @(negedge clk);
        chk("post_reset_acc", 32'(acc), 32'd0);

        // Directed sequences
        issue(4'd1, 8'h7F); issue(4'd2, 8'h01); drain();
        chk_state("add_ovf", 'h80, 4'b0101);
        issue(4'd1, 8'h05); issue(4'd4, 8'h05); drain();
        chk_state("sub_eq", 0, 4'b1010);
        issue(4'd4, 8'h01); drain();
        chk_state("sub_borrow", 'hFF, 4'b0100);
        issue(4'd1, 8'hFF); issue(4'd2, 8'h01); drain();
        chk_state("add_carry", 0, 4'b1010);
        issue(4'd3, 8'h00); drain();
        chk_state("adc", 'h01, 4'b0000);
        issue(4'd7, 8'h00); drain();
        chk_state("not", 'hFE, 4'b0100);
        issue(4'd1, 8'h0D); issue(4'd9, 8'h0B); drain();
        chk_state("mul_8f", 'h8F, 4'b0100);
        issue(4'd1, 8'hF0); issue(4'd9, 8'h03); drain();
        chk_state("mul_carry", 'hD0, 4'b0110);

        // Reset in the middle of a multiply: no writeback, no done
        issue(4'd1, 8'h0D);
        drain();
        op_valid = 1'b1; opcode = 4'd9; operand = 8'h0B;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1; op_valid = 1'b1;
        #1;
        chk_state("midmul_reset", 0, 4'b0000);
        chk("midmul_ready", 32'(op_ready), 32'd1);
        m_acc = 0; m_z = 0; m_n = 0; m_c = 0; m_v = 0;
        @(negedge clk);
        rst = 1'b0; op_valid = 1'b0;
        repeat (12) @(negedge clk);
        chk_state("midmul_after", 0, 4'b0000);

        issue(4'd1, 8'h3C); issue(4'hF, 8'hA5); drain();
        chk_state("illegal_hold", 'h3C, 4'b0000);

        // Randomized traffic, including back-to-back ops and busy-time junk
        for (int k = 0; k < 300; k++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                             : 4'($urandom_range(0, 9));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(op, 8'($urandom));
        end
        drain();
        chk("final_queue_empty", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/acc_exec_ctrl.md
Name: acc_exec_ctrl

Overview:
Execution controller for the accumulator-based processor. It sits directly upstream and downstream of the combinational n-bit ALU. It accepts one operation per handshake, drives the ALU operand, carry and control lines, and writes the ALU result back into the accumulator and Z/N/C/V flag register. It also runs an n-cycle shift-and-add multiply by reusing the ALU adder.

Parameters:
n, 8, data width of the accumulator, operand and ALU interface

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
op_valid  input  1  operation request
op_ready  output  1  high when the controller can accept an operation (state IDLE)
opcode  input  4  operation code, sampled only at accept
operand  input  n  memory/immediate operand, sampled only at accept
alu_in0  output  n  ALU input 0
alu_in1  output  n  ALU input 1
alu_c_in  output  1  ALU carry in
alu_ctrl  output  3  ALU control
alu_out  input  n  ALU result
alu_c_out  input  1  ALU carry out
alu_v  input  1  ALU overflow
acc  output  n  accumulator register
flag_z, flag_n, flag_c, flag_v  output  1 each  status flags
done  output  1  one-cycle pulse after writeback
illegal  output  1  one-cycle pulse with done for an undefined opcode

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. On reset: state IDLE, acc=0, all flags 0, done=0, illegal=0, internal regs 0. op_ready is combinational (state==IDLE), so it is 1 during and after reset.
- Accept: a transfer occurs on a rising edge with op_valid && op_ready. opcode and operand are registered at that edge. op_valid while busy is ignored; no queueing.
- Opcodes:
  - 0 NOP
  - 1 LDA: acc=operand
  - 2 ADD: acc+operand, c_in=0
  - 3 ADC: acc+operand, c_in=flag_c
  - 4 SUB: alu_ctrl=001, c_in=1
  - 5 OR: ctrl 010
  - 6 AND: ctrl 100
  - 7 NOT: ctrl 110, result ~acc
  - 8 CLR: acc=0
  - 9 MUL
  - 10-15: illegal
- FSM for single-cycle ops: IDLE -> EXEC -> IDLE.
  - In EXEC the controller drives alu_in0=acc and alu_in1=operand_reg. acc and flags are written at the edge ending EXEC.
  - done (and illegal, if applicable) is a registered pulse high in the following IDLE cycle.
  - op_ready is low for exactly 1 cycle, so the maximum rate is one op per 2 cycles. A new op can be accepted on the same edge that ends the done cycle.
- Idle drive: outside EXEC/MUL the ALU lines are driven alu_ctrl=000, alu_in0=0, alu_in1=0, alu_c_in=0.
- Flags:
  - Z=(new acc==0) and N=new acc[n-1] are updated by every op that writes acc (LDA, arithmetic, logic, CLR, MUL).
  - ADD/ADC/SUB set C=alu_c_out and V=alu_v. SUB C is the no-borrow convention: 1 when acc>=operand unsigned.
  - OR/AND/NOT clear C and V.
  - LDA/CLR hold C and V.
  - NOP/illegal change nothing.
- MUL FSM: IDLE -> MUL (n cycles, counter 0..n-1) -> IDLE.
  - On accept: mcand=acc, mplier=operand, prod=0, sticky carry cleared.
  - Step i: alu_ctrl=000, alu_c_in=0, alu_in0=prod, alu_in1=(mplier[i] ? (mcand<<i) truncated to n : 0).
  - At each step edge: prod=alu_out, sticky |= alu_c_out.
  - At the final edge (i=n-1): acc=alu_out, C=sticky, V=0, Z/N from the result.
  - Result is the low n bits of the unsigned product. C is not a full overflow indicator: bits shifted out of mcand are not counted.
  - op_ready is low for n cycles; done pulses the cycle after.
- Reset mid-operation: EXEC/MUL is aborted immediately. No writeback and no done pulse.
- Counter: width is clog2(n). It wraps only via the state exit. It is not reset by op_valid.

Decomposition:
- Shared package / header:
  - opcode constants (OP_NOP..OP_MUL)
  - ALU ctrl codes (ALU_ADD=000, ALU_SUB=001, ALU_OR=010, ALU_AND=100, ALU_NOTA=110)
  - FSM state encoding (IDLE, EXEC, MUL)
- Natural sub-module: acc_flag_reg. It holds acc plus Z/N/C/V with separate load enables for the acc/ZN group and the C/V group.
- The FSM, operand registers and MUL datapath stay in the top.
- The bench connects a real alu_nbit to the ALU ports.

Test Plan:
- Reset -> acc=0x00, all flags 0, op_ready=1, done=0. Assert rst while op_valid=1 -> nothing accepted.
- LDA 0x7F then ADD 0x01 -> acc=0x80, N=1, V=1, C=0, Z=0. op_ready low 1 cycle per op; done pulses 2 cycles after each accept edge.
- LDA 0x05, SUB 0x05 -> acc=0x00, Z=1, C=1, V=0. Then SUB 0x01 -> acc=0xFF, N=1, C=0.
- LDA 0xFF, ADD 0x01 -> acc=0x00, C=1, Z=1. Then ADC 0x00 -> acc=0x01, C=0. Then NOT -> acc=0xFE, C=0, V=0.
- LDA 0x0D, MUL 0x0B -> acc=0x8F after 8 MUL cycles, C=0. LDA 0xF0, MUL 0x03 -> acc=0xD0, C=1. op_ready low exactly 8 cycles each.
- MUL in progress, rst pulse in step 4 -> acc=0, IDLE, no done. Then opcode 0xF -> done and illegal pulse together, acc and flags unchanged.
